// File: rtl/decode_stage_reg.sv
// rtl/decode_stage_reg.sv - registered ID/EX decode slice with valid/ready skid buffer and flush
// Optional operand bypass from write-back is enabled with `define DECODE_BYPASS_EN.
module decode_stage_reg #(
  parameter int DATA_W = 32,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 3,
  parameter int EXE_W  = 4,
  parameter int REG_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WB_W+MEM_W+EXE_W-1:0]   decoder_in,
  input  logic [DATA_W-1:0]             dataA_in,
  input  logic [DATA_W-1:0]             dataB_in,
  input  logic [31:0]                   instr_in,
  input  logic                          ls,
  input  logic                          zext,
`ifdef DECODE_BYPASS_EN
  input  logic                          wb_we,
  input  logic [REG_W-1:0]              wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WB_W-1:0]               WB_out,
  output logic [MEM_W-1:0]              MEM_out,
  output logic [EXE_W-1:0]              EXE_out,
  output logic [REG_W-1:0]              RS_out,
  output logic [REG_W-1:0]              RT_out,
  output logic [REG_W-1:0]              RD_out,
  output logic [DATA_W-1:0]             dataA_out,
  output logic [DATA_W-1:0]             dataB_out,
  output logic [DATA_W-1:0]             imm_out
);

  localparam int CW = WB_W + MEM_W + EXE_W;
  localparam int PW = CW + 3*REG_W + 3*DATA_W;

  logic [REG_W-1:0]  rs, rt, rd;
  logic [DATA_W-1:0] opa, opb, imm;
  logic [PW-1:0]     pay, or_q, sk_q;
  logic              or_v, sk_v, fire, accept;
  logic              unused_instr;

  assign rs = instr_in[21 +: REG_W];
  assign rt = instr_in[16 +: REG_W];
  assign rd = instr_in[11 +: REG_W];
  assign unused_instr = &{1'b0, instr_in[31:26]};

  always_comb begin
    opa = ls ? {{(DATA_W-5){1'b0}}, instr_in[25:21]} : dataA_in;
    opb = dataB_in;
`ifdef DECODE_BYPASS_EN
    if (wb_we && (wb_rd != '0)) begin
      if (!ls && (wb_rd == rs)) opa = wb_data;
      if (wb_rd == rt)          opb = wb_data;
    end
`endif
    imm = zext ? {{(DATA_W-16){1'b0}}, instr_in[15:0]}
               : {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
  end

  assign pay    = {decoder_in, rs, rt, rd, opa, opb, imm};
  assign in_ready = !sk_v;
  assign fire   = or_v && out_ready;
  assign accept = in_valid && in_ready && !flush;

  // Control field is zeroed whenever OR goes empty so bubbles carry no side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q <= '0;
      sk_q <= '0;
      or_v <= 1'b0;
      sk_v <= 1'b0;
    end else if (flush) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_q[PW-1 -: CW] <= '0;
    end else if (!or_v || fire) begin
      if (sk_v) begin
        or_q <= sk_q;
        or_v <= 1'b1;
        sk_v <= 1'b0;
      end else if (accept) begin
        or_q <= pay;
        or_v <= 1'b1;
      end else begin
        or_v <= 1'b0;
        or_q[PW-1 -: CW] <= '0;
      end
    end else if (accept) begin
      sk_q <= pay;
      sk_v <= 1'b1;
    end
  end

  assign out_valid = or_v;
  assign {WB_out, MEM_out, EXE_out, RS_out, RT_out, RD_out,
          dataA_out, dataB_out, imm_out} = or_q;

endmodule
